// File: rtl/ws2812_pkg.sv
// Shared state encoding, 50 MHz timing defaults and a width helper for the
// WS2812 frame sequencer.
package ws2812_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_SEND  = 2'd2;
    localparam state_t ST_LATCH = 2'd3;

    localparam int unsigned NUM_LEDS_DEF     = 32'd60;
    localparam int unsigned T0H_DEF          = 32'd20;
    localparam int unsigned T1H_DEF          = 32'd40;
    localparam int unsigned TBIT_DEF         = 32'd63;
    localparam int unsigned RESET_CYCLES_DEF = 32'd2750;
    localparam int unsigned REQ_LATENCY_DEF  = 32'd1;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int unsigned clog2_f(input int unsigned value);
        int unsigned width;
        int unsigned span;
        width = 32'd0;
        span  = 32'd1;
        while (span < value) begin
            span  = span << 1'b1;
            width = width + 32'd1;
        end
        return (width == 32'd0) ? 32'd1 : width;
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Shapes one WS2812 bit: dout high for T0H/T1H cycles, low for the rest of TBIT.
// A start strobe on the last cycle of a bit chains the next bit seamlessly.
module ws2812_bit_encoder
    import ws2812_pkg::*;
#(
    parameter int unsigned T0H  = T0H_DEF,
    parameter int unsigned T1H  = T1H_DEF,
    parameter int unsigned TBIT = TBIT_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic bit_i,
    output logic dout_o,
    output logic bit_first_o,
    output logic bit_done_o
);

    localparam int unsigned CNT_W = clog2_f(TBIT);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TBIT - 1);
    localparam logic [CNT_W-1:0] T0H_C    = CNT_W'(T0H);
    localparam logic [CNT_W-1:0] T1H_C    = CNT_W'(T1H);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             val_q, val_d;
    logic             dout_q, dout_d;
    logic [CNT_W-1:0] thigh_s;

    // Next-state for the bit-cycle counter and the registered line level.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        val_d    = val_q;
        dout_d   = 1'b0;
        thigh_s  = val_q ? T1H_C : T0H_C;
        if (start_i) begin
            cnt_d    = CNT_ZERO;
            active_d = 1'b1;
            val_d    = bit_i;
            dout_d   = 1'b1;
        end else if (active_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d    = CNT_ZERO;
                active_d = 1'b0;
                dout_d   = 1'b0;
            end else begin
                cnt_d  = cnt_q + CNT_ONE;
                dout_d = ((cnt_q + CNT_ONE) < thigh_s);
            end
        end else begin
            dout_d = 1'b0;
        end
    end

    // State registers; reset forces the line low without waiting for a clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= CNT_ZERO;
            active_q <= 1'b0;
            val_q    <= 1'b0;
            dout_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            val_q    <= val_d;
            dout_q   <= dout_d;
        end
    end

    assign dout_o      = dout_q;
    assign bit_first_o = active_q && (cnt_q == CNT_ZERO);
    assign bit_done_o  = active_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// Pulls 3*NUM_LEDS colour bytes per frame from the source, streams them MSB
// first as WS2812 bits, then holds the latch gap before the next frame.
module ws2812_frame_sequencer
    import ws2812_pkg::*;
#(
    parameter int unsigned NUM_LEDS     = NUM_LEDS_DEF,
    parameter int unsigned T0H          = T0H_DEF,
    parameter int unsigned T1H          = T1H_DEF,
    parameter int unsigned TBIT         = TBIT_DEF,
    parameter int unsigned RESET_CYCLES = RESET_CYCLES_DEF,
    parameter int unsigned REQ_LATENCY  = REQ_LATENCY_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [7:0] color_in_i,
    output logic       data_request_o,
    output logic       frame_start_o,
    output logic       busy_o,
    output logic       dout_o
);

    localparam int unsigned NUM_BYTES = 3 * NUM_LEDS;
    localparam int unsigned BYTE_W    = clog2_f(NUM_BYTES);
    localparam int unsigned TMR_SPAN  = (TBIT > RESET_CYCLES) ? TBIT : RESET_CYCLES;
    localparam int unsigned TMR_W     = clog2_f(TMR_SPAN);

    localparam logic [BYTE_W-1:0] BYTE_ZERO  = BYTE_W'(0);
    localparam logic [BYTE_W-1:0] BYTE_ONE   = BYTE_W'(1);
    localparam logic [BYTE_W-1:0] BYTE_LAST  = BYTE_W'(NUM_BYTES - 1);
    localparam logic [TMR_W-1:0]  TMR_ZERO   = TMR_W'(0);
    localparam logic [TMR_W-1:0]  TMR_ONE    = TMR_W'(1);
    localparam logic [TMR_W-1:0]  LAT_LAST   = TMR_W'(REQ_LATENCY);
    localparam logic [TMR_W-1:0]  LATCH_LAST = TMR_W'(RESET_CYCLES - 1);

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        next_q, next_d;
    logic              req_q, req_d;
    logic              fs_q, fs_d;
    logic              busy_q, busy_d;

    logic              enc_start_s;
    logic              enc_bit_s;
    logic              enc_first_s;
    logic              enc_done_s;
    logic              capture_s;
    logic              prefetch_arm_s;
    logic [7:0]        nxt_byte_s;

    ws2812_bit_encoder #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_bit_encoder (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (enc_start_s),
        .bit_i       (enc_bit_s),
        .dout_o      (dout_o),
        .bit_first_o (enc_first_s),
        .bit_done_o  (enc_done_s)
    );

    // Frame FSM, byte/bit bookkeeping and prefetch of the following byte.
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        next_d      = next_q;
        req_d       = 1'b0;
        fs_d        = 1'b0;
        enc_start_s = 1'b0;
        enc_bit_s   = 1'b0;
        // In SEND the timer only runs while a prefetched byte is in flight.
        capture_s      = (state_q == ST_SEND) && (tmr_q == LAT_LAST);
        nxt_byte_s     = capture_s ? color_in_i : next_q;
        prefetch_arm_s = enc_first_s && (bit_cnt_q == 3'd7) && (byte_cnt_q != BYTE_LAST);

        case (state_q)
            ST_IDLE: begin
                tmr_d = TMR_ZERO;
                if (enable_i) begin
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                    fs_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (tmr_q == LAT_LAST) begin
                    shift_d     = color_in_i;
                    enc_start_s = 1'b1;
                    enc_bit_s   = color_in_i[7];
                    bit_cnt_d   = 3'd0;
                    byte_cnt_d  = BYTE_ZERO;
                    tmr_d       = TMR_ZERO;
                    state_d     = ST_SEND;
                end else begin
                    tmr_d = tmr_q + TMR_ONE;
                end
            end
            ST_SEND: begin
                if (capture_s) begin
                    next_d = color_in_i;
                    tmr_d  = TMR_ZERO;
                end else if (tmr_q != TMR_ZERO) begin
                    tmr_d = tmr_q + TMR_ONE;
                end else if (prefetch_arm_s) begin
                    tmr_d = TMR_ONE;
                end else begin
                    tmr_d = tmr_q;
                end

                if (enc_done_s) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q != 3'd7) begin
                        enc_start_s = 1'b1;
                        enc_bit_s   = shift_q[~(bit_cnt_q + 3'd1)];
                        req_d       = (bit_cnt_q == 3'd6) && (byte_cnt_q != BYTE_LAST);
                    end else if (byte_cnt_q == BYTE_LAST) begin
                        state_d = ST_LATCH;
                        tmr_d   = TMR_ZERO;
                    end else begin
                        byte_cnt_d  = byte_cnt_q + BYTE_ONE;
                        shift_d     = nxt_byte_s;
                        enc_start_s = 1'b1;
                        enc_bit_s   = nxt_byte_s[7];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            ST_LATCH: begin
                if (tmr_q == LATCH_LAST) begin
                    tmr_d = TMR_ZERO;
                    if (enable_i) begin
                        state_d = ST_FETCH;
                        req_d   = 1'b1;
                        fs_d    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmr_d   = TMR_ZERO;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer state and registered strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            tmr_q      <= TMR_ZERO;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= BYTE_ZERO;
            shift_q    <= 8'h00;
            next_q     <= 8'h00;
            req_q      <= 1'b0;
            fs_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            next_q     <= next_d;
            req_q      <= req_d;
            fs_q       <= fs_d;
            busy_q     <= busy_d;
        end
    end

    assign data_request_o = req_q;
    assign frame_start_o  = fs_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Two sequencers (request latency 1 and 3) run against a cycle-level reference
// derived from frame arithmetic, with randomised enable activity and colours.
module tb_ws2812_frame_sequencer;

    localparam int N  = 2;
    localparam int T0 = 2;
    localparam int T1 = 4;
    localparam int TB = 6;
    localparam int RC = 10;
    localparam int NB = 3 * N;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] dout_w;
    logic [1:0] req_w;
    logic [1:0] fs_w;
    logic [1:0] busy_w;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    function automatic logic [7:0] first_byte(input int j);
        case (j)
            0:       return 8'hA5;
            1:       return 8'h3C;
            2:       return 8'hFF;
            3:       return 8'h00;
            4:       return 8'h81;
            default: return 8'h7E;
        endcase
    endfunction

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : 3;
        localparam int FL  = LAT + 1;
        localparam int BT  = 24 * N * TB;
        localparam int LEN = FL + BT + RC;

        logic [7:0] color = 8'h00;
        logic [7:0] fbytes [NB];
        bit         in_frame   = 1'b0;
        bit         start_next = 1'b0;
        int         k = 0, tcyc = 0, req_idx = NB, reqs_seen = 0, nframes = 0;
        int         pend_q[$];

        ws2812_frame_sequencer #(
            .NUM_LEDS     (N),
            .T0H          (T0),
            .T1H          (T1),
            .TBIT         (TB),
            .RESET_CYCLES (RC),
            .REQ_LATENCY  (LAT)
        ) u_dut (
            .clk_i          (clk),
            .rst_ni         (rst_n),
            .enable_i       (enable),
            .color_in_i     (color),
            .data_request_o (req_w[g]),
            .frame_start_o  (fs_w[g]),
            .busy_o         (busy_w[g]),
            .dout_o         (dout_w[g])
        );

        // Reference model plus colour source, evaluated mid-cycle.
        always @(negedge clk) begin : mon
            int   kp, b, cb;
            logic e_fs, e_req, e_dout, e_busy, bv;
            tcyc++;
            if (!rst_n) begin
                in_frame   = 1'b0;
                start_next = 1'b0;
                req_idx    = NB;
                pend_q.delete();
                color      = 8'($urandom);
            end else begin
                if (start_next) begin
                    start_next = 1'b0;
                    in_frame   = 1'b1;
                    k          = 0;
                    reqs_seen  = 0;
                    req_idx    = 0;
                    for (int j = 0; j < NB; j++)
                        fbytes[j] = (nframes == 0) ? first_byte(j) : 8'($urandom);
                    nframes++;
                end else if (in_frame) begin
                    k++;
                end

                e_fs = 1'b0; e_req = 1'b0; e_dout = 1'b0; e_busy = 1'b0;
                if (in_frame) begin
                    e_busy = 1'b1;
                    e_fs   = (k == 0);
                    e_req  = (k == 0);
                    kp     = k - FL;
                    if (kp >= 0 && kp < BT) begin
                        b      = kp / TB;
                        cb     = kp % TB;
                        bv     = fbytes[b / 8][7 - (b % 8)];
                        e_dout = (cb < (bv ? T1 : T0));
                        e_req  = (cb == 0) && (b % 8 == 7) && (b / 8 < NB - 1);
                    end
                end
                check_eq($sformatf("L%0d_dout", LAT), dout_w[g], e_dout);
                check_eq($sformatf("L%0d_data_request", LAT), req_w[g], e_req);
                check_eq($sformatf("L%0d_frame_start", LAT), fs_w[g], e_fs);
                check_eq($sformatf("L%0d_busy", LAT), busy_w[g], e_busy);

                if (req_w[g]) begin
                    reqs_seen++;
                    pend_q.push_back(tcyc);
                end

                if (in_frame) begin
                    if (k == LEN - 1) begin
                        check_eq($sformatf("L%0d_requests_per_frame", LAT), reqs_seen, NB);
                        in_frame   = 1'b0;
                        start_next = enable;
                    end
                end else begin
                    start_next = enable;
                end

                if (pend_q.size() > 0 && pend_q[0] == tcyc - LAT) begin
                    void'(pend_q.pop_front());
                    color = (req_idx < NB) ? fbytes[req_idx] : 8'($urandom);
                    req_idx++;
                end else begin
                    color = 8'($urandom);
                end
            end
        end
    end

    task automatic wait_fs0(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (fs_w[0]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (busy_w == 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin : stim
        bit ok;
        int cnt;
        repeat (3) @(negedge clk);
        check_eq("reset_dout", dout_w, 2'b00);
        check_eq("reset_data_request", req_w, 2'b00);
        check_eq("reset_frame_start", fs_w, 2'b00);
        check_eq("reset_busy", busy_w, 2'b00);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 enable = 1'b1;
        repeat (700) @(posedge clk);

        // Drop enable while lane 0 is in its third byte.
        wait_fs0(ok);
        check_eq("wait_frame_start_a", ok, 1'b1);
        repeat (100) @(posedge clk);
        #1 enable = 1'b0;
        wait_idle(ok);
        check_eq("idle_after_drop", ok, 1'b1);
        repeat (30) @(posedge clk);

        // Random enable activity.
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1 enable = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 150)) @(posedge clk);
        end

        // Enable low mid-frame, reasserted inside the latch gap.
        @(posedge clk);
        #1 enable = 1'b1;
        wait_fs0(ok);
        check_eq("wait_frame_start_b", ok, 1'b1);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == 50) enable = 1'b0;
            if (cnt == 2 + 24 * N * TB + 3) enable = 1'b1;
            if (fs_w[0]) break;
        end
        check_eq("latch_reassert_period", cnt, 2 + 24 * N * TB + RC);

        // Asynchronous reset while lane 0 drives a high level.
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (dout_w[0]) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("wait_dout_high", ok, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("async_rst_dout", dout_w, 2'b00);
        check_eq("async_rst_data_request", req_w, 2'b00);
        check_eq("async_rst_frame_start", fs_w, 2'b00);
        check_eq("async_rst_busy", busy_w, 2'b00);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (700) @(posedge clk);
        #1 enable = 1'b0;
        wait_idle(ok);
        check_eq("final_idle", ok, 1'b1);
        repeat (20) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
